pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
Program-counter and return-stack datapath stage directly downstream of the sequence control matrix. It consumes the PC_Rst/PC_Inc/PC_Ld/PC_Src/BRA_Src/STK_Ld strobes and drives the registered PC, which feeds the MUX_ADDR PC input (ADDR_Src=00) for instruction fetch. It holds a small LIFO of return addresses for call and return, with full/empty status and a sticky error flag.

Parameters:
AddrWidth, 8, width of PC, branch target and stack entries
StackDepth, 4, number of return-stack entries (power of 2, >=2)

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high; clears all state
PC_Rst  input  1  active-low; forces PC to 0 and clears stack and error
PC_Inc  input  1  active-low; PC <= PC+1
PC_Ld  input  1  active-low; PC <= source chosen by PC_Src
PC_Src  input  2  00 branch target, 01 stack pop (return), 10 Reg_Data, 11 hold
BRA_Src  input  1  0 absolute target = Imm; 1 PC-relative (see Optional Feature)
STK_Ld  input  1  active-high; push return address PC+1
Imm  input  AddrWidth  branch immediate from IR
Reg_Data  input  AddrWidth  register-file value for indirect jump
PC  output  AddrWidth  current program counter
Stk_Full  output  1  stack holds StackDepth entries
Stk_Empty  output  1  stack holds 0 entries
Stk_Err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset=1 at a rising edge: PC=0, stack pointer=0, Stk_Empty=1, Stk_Full=0, Stk_Err=0. Reset has priority over all strobes and takes effect mid-operation, discarding any in-flight push or pop.
- PC update priority per cycle: Reset > PC_Rst=0 > PC_Ld=0 > PC_Inc=0 > hold.
- PC_Rst=0 has the same effect as Reset: it also clears the stack and Stk_Err.
- All arithmetic is modulo 2^AddrWidth. Incrementing from all-ones wraps to 0 with no flag.
- Latency: every load, increment and pop is visible on PC in the cycle after the edge. PC is a register output, not combinational.
- PC_Ld with PC_Src=00: target = Imm (BRA_Src=0) or the relative target.
- PC_Ld with PC_Src=10: PC <= Reg_Data.
- PC_Ld with PC_Src=11: PC holds. This is not an error.
- PC_Ld with PC_Src=01 (pop): PC <= top entry and the pointer decrements.
- Pop when the stack is empty: PC holds, pointer unchanged, Stk_Err <= 1.
- Push (STK_Ld=1): writes the current PC+1 (wrapped) to the top and the pointer increments.
- Push when full: no write, pointer unchanged, Stk_Err <= 1. PC updates normally.
- Push and pop in the same cycle:
  - PC <= old top, and the old top slot is overwritten with PC+1.
  - Net depth is unchanged.
  - If the stack is empty, this is an underflow (Stk_Err=1) and the push is also dropped.
- Push is independent of PC_Inc/PC_Ld. A call is STK_Ld=1 with PC_Ld=0 and PC_Src=00 in the same cycle.
- STK_Ld is ignored when PC_Rst=0.
- Stk_Full and Stk_Empty are combinational decodes of the registered pointer. The pointer is log2(StackDepth)+1 bits, so full and empty are unambiguous.
- Stk_Err stays set until Reset or PC_Rst=0.
- Undriven strobe inputs at power-up are don't-care. Reset must be asserted once before use.

Optional Feature:
Macro PC_RELATIVE_EN.
- Defined: with BRA_Src=1 and PC_Src=00, target = PC + sign-extended Imm (Imm is two's complement, AddrWidth bits, range -2^(AddrWidth-1) .. +2^(AddrWidth-1)-1), wrapped modulo 2^AddrWidth.
- Not defined: BRA_Src is ignored, the target is always Imm (absolute), and the adder is not synthesised.

Test Plan:
- Reset=1 for 2 cycles, then release -> PC=0x00, Stk_Empty=1, Stk_Full=0, Stk_Err=0.
- PC_Ld=0, PC_Src=10, Reg_Data=0xFE; then PC_Inc=0 for 3 cycles -> PC sequence 0xFE, 0xFF, 0x00, 0x01 (wrap), Stk_Err=0.
- PC=0x10, then call: STK_Ld=1, PC_Ld=0, PC_Src=00, Imm=0x40 -> PC=0x40, depth 1. Then return: PC_Ld=0, PC_Src=01 -> PC=0x11, Stk_Empty=1.
- 4 calls from PC=0x20/0x30/0x40/0x50 -> Stk_Full=1. 5th push -> Stk_Err=1, depth stays 4. 4 pops return 0x51, 0x41, 0x31, 0x21. 5th pop: PC holds 0x21, Stk_Err stays 1. Then PC_Rst=0 -> PC=0, Stk_Err=0.
- Depth 1 (top=0x11), PC=0x60, STK_Ld=1 with pop -> PC=0x11, top=0x61, depth 1.
- With PC_RELATIVE_EN: PC=0x05, BRA_Src=1, Imm=0xFA (-6) -> PC=0xFF. Without the macro, the same stimulus -> PC=0xFA.

Source files
------------

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: registered PC with return-address LIFO; PC-relative branch target when PC_RELATIVE_EN is defined
module pc_branch_unit #(
  parameter int AddrWidth  = 8,
  parameter int StackDepth = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 PC_Rst,
  input  logic                 PC_Inc,
  input  logic                 PC_Ld,
  input  logic [1:0]           PC_Src,
  input  logic                 BRA_Src,
  input  logic                 STK_Ld,
  input  logic [AddrWidth-1:0] Imm,
  input  logic [AddrWidth-1:0] Reg_Data,
  output logic [AddrWidth-1:0] PC,
  output logic                 Stk_Full,
  output logic                 Stk_Empty,
  output logic                 Stk_Err
);
  localparam int PW = $clog2(StackDepth) + 1;
  localparam int IW = PW - 1;
  logic [AddrWidth-1:0] pc_q, pc_d, pc_inc, target, top;
  logic [AddrWidth-1:0] stk_q [StackDepth];
  logic [AddrWidth-1:0] stk_d [StackDepth];
  logic [PW-1:0] sp_q, sp_d;
  logic err_q, err_d;
  logic push, pop, wr_en;
  logic [IW-1:0] top_idx, wr_idx;
  assign push      = STK_Ld && PC_Rst;
  assign pop       = !PC_Ld && (PC_Src == 2'b01);
  assign Stk_Empty = (sp_q == '0);
  assign Stk_Full  = (sp_q == PW'(StackDepth));
  assign top_idx   = sp_q[IW-1:0] - IW'(1);
  assign top       = stk_q[top_idx];
  assign pc_inc    = pc_q + AddrWidth'(1);
`ifdef PC_RELATIVE_EN
  // Same-width add of a two's-complement Imm is the sign-extended add modulo 2^AddrWidth
  assign target = BRA_Src ? pc_q + Imm : Imm;
`else
  logic unused_bra_src;
  assign unused_bra_src = BRA_Src;
  assign target         = Imm;
`endif
  // A combined push+pop overwrites the old top; a lone push writes above it
  assign wr_idx = pop ? top_idx : sp_q[IW-1:0];
  assign wr_en  = push && (pop ? !Stk_Empty : !Stk_Full);
  // Next-state: PC priority PC_Rst > PC_Ld > PC_Inc > hold; stack pointer moves only on an unpaired push or pop
  always_comb begin
    stk_d = stk_q;
    if (wr_en) stk_d[wr_idx] = pc_inc;
    pc_d  = !PC_Rst ? '0 :
            !PC_Ld  ? (PC_Src == 2'b00 ? target :
                       PC_Src == 2'b01 ? (Stk_Empty ? pc_q : top) :
                       PC_Src == 2'b10 ? Reg_Data : pc_q) :
            !PC_Inc ? pc_inc : pc_q;
    sp_d  = !PC_Rst                        ? '0 :
            (pop && !push && !Stk_Empty)   ? sp_q - PW'(1) :
            (push && !pop && !Stk_Full)    ? sp_q + PW'(1) : sp_q;
    err_d = PC_Rst && (err_q || (pop && Stk_Empty) || (push && !pop && Stk_Full));
  end
  // State registers with synchronous reset that discards any in-flight push or pop
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
      stk_q <= '{default: '0};
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      stk_q <= stk_d;
    end
  end
  assign PC      = pc_q;
  assign Stk_Err = err_q;
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed vectors with a queue scoreboard checked by an independent monitor
module tb_pc_branch_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1, pc_rst = 1'b1, pc_inc = 1'b1, pc_ld = 1'b1, bra_src = 1'b0, stk_ld = 1'b0;
  logic [1:0] pc_src = 2'b11;
  logic [7:0] imm = '0, reg_data = '0;
  logic [7:0] pc;
  logic       stk_full, stk_empty, stk_err;
  typedef struct {
    string      name;
    logic [7:0] pc;
    logic       full, empty, err;
  } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  pc_branch_unit #(.AddrWidth(8), .StackDepth(4)) dut (
    .Clk(clk), .Reset(reset), .PC_Rst(pc_rst), .PC_Inc(pc_inc), .PC_Ld(pc_ld),
    .PC_Src(pc_src), .BRA_Src(bra_src), .STK_Ld(stk_ld), .Imm(imm), .Reg_Data(reg_data),
    .PC(pc), .Stk_Full(stk_full), .Stk_Empty(stk_empty), .Stk_Err(stk_err)
  );
  always #5 clk = ~clk;
  // Monitor: each queued expectation describes the outputs after one edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (pc !== e.pc || stk_full !== e.full || stk_empty !== e.empty || stk_err !== e.err) begin
        miscompares++;
        $display("FAIL %s: got pc=%h full=%b empty=%b err=%b, expected pc=%h full=%b empty=%b err=%b",
                 e.name, pc, stk_full, stk_empty, stk_err, e.pc, e.full, e.empty, e.err);
      end
    end
  end
  task automatic step(input string name, input logic r, input logic prst_n, input logic inc_n,
                      input logic ld_n, input logic [1:0] src, input logic bra, input logic stk,
                      input logic [7:0] im, input logic [7:0] rd,
                      input logic [7:0] epc, input logic ef, input logic ee, input logic eerr);
    exp_t e;
    @(negedge clk);
    reset = r; pc_rst = prst_n; pc_inc = inc_n; pc_ld = ld_n; pc_src = src;
    bra_src = bra; stk_ld = stk; imm = im; reg_data = rd;
    @(posedge clk);
    #1;
    e.name = name; e.pc = epc; e.full = ef; e.empty = ee; e.err = eerr;
    q.push_back(e);
  endtask
  task automatic ld_reg(input string n, input logic [7:0] v, input logic ef, input logic ee, input logic er);
    step(n, 0, 1, 1, 0, 2'b10, 0, 0, 8'h00, v, v, ef, ee, er);
  endtask
  task automatic call(input string n, input logic [7:0] t, input logic ef, input logic ee, input logic er);
    step(n, 0, 1, 1, 0, 2'b00, 0, 1, t, 8'h00, t, ef, ee, er);
  endtask
  task automatic ret(input string n, input logic [7:0] epc, input logic ef, input logic ee, input logic er);
    step(n, 0, 1, 1, 0, 2'b01, 0, 0, 8'h00, 8'h00, epc, ef, ee, er);
  endtask
  initial begin
    logic [7:0] rel_exp;
`ifdef PC_RELATIVE_EN
    rel_exp = 8'hFF;
`else
    rel_exp = 8'hFA;
`endif
    step("reset1", 1, 1, 1, 1, 2'b11, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    step("reset2", 1, 1, 1, 1, 2'b11, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    step("idle_after_reset", 0, 1, 1, 1, 2'b11, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    ld_reg("ld_reg_fe", 8'hFE, 0, 1, 0);
    step("inc_ff", 0, 1, 0, 1, 2'b11, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 1, 0);
    step("inc_wrap_00", 0, 1, 0, 1, 2'b11, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    step("inc_01", 0, 1, 0, 1, 2'b11, 0, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0);
    step("ld_beats_inc", 0, 1, 0, 0, 2'b10, 0, 0, 8'h00, 8'h10, 8'h10, 0, 1, 0);
    call("call_40", 8'h40, 0, 0, 0);
    ret("ret_11", 8'h11, 0, 1, 0);
    ld_reg("ld_20", 8'h20, 0, 1, 0);
    call("call_from_20", 8'h30, 0, 0, 0);
    call("call_from_30", 8'h40, 0, 0, 0);
    call("call_from_40", 8'h50, 0, 0, 0);
    call("call_from_50_full", 8'h60, 1, 0, 0);
    call("push_overflow", 8'h70, 1, 0, 1);
    ret("pop_51", 8'h51, 0, 0, 1);
    ret("pop_41", 8'h41, 0, 0, 1);
    ret("pop_31", 8'h31, 0, 0, 1);
    ret("pop_21", 8'h21, 0, 1, 1);
    ret("pop_underflow_hold", 8'h21, 0, 1, 1);
    step("pc_rst_clears", 0, 0, 1, 1, 2'b11, 0, 1, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    ld_reg("ld_10", 8'h10, 0, 1, 0);
    call("call_60_top_11", 8'h60, 0, 0, 0);
    step("push_pop_swap", 0, 1, 1, 0, 2'b01, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0, 0);
    ret("pop_new_top_61", 8'h61, 0, 1, 0);
    step("ld_src11_hold", 0, 1, 1, 0, 2'b11, 0, 0, 8'h00, 8'h00, 8'h61, 0, 1, 0);
    ld_reg("ld_05", 8'h05, 0, 1, 0);
    step("branch_bra1", 0, 1, 1, 0, 2'b00, 1, 0, 8'hFA, 8'h00, rel_exp, 0, 1, 0);
    step("branch_abs", 0, 1, 1, 0, 2'b00, 0, 0, 8'h33, 8'h00, 8'h33, 0, 1, 0);
    step("push_pop_empty", 0, 1, 1, 0, 2'b01, 0, 1, 8'h00, 8'h00, 8'h33, 0, 1, 1);
    step("push_after_err", 0, 1, 1, 1, 2'b11, 0, 1, 8'h00, 8'h00, 8'h33, 0, 0, 1);
    step("reset_mid_push", 1, 1, 0, 1, 2'b11, 0, 1, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    step("hold_idle", 0, 1, 1, 1, 2'b11, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
